// File: rtl/ssd_scan_if.sv
// Display-side bus of the seven-segment scan engine: per-digit frame data and
// load strobe in, anode/cathode pins and scan position out.
interface ssd_scan_if #(
  parameter int N_DIGITS = 8,
  parameter int PWM_BITS = 4
);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [N_DIGITS-1:0]   blink_in;
  logic                  lz_suppress;
  logic [PWM_BITS-1:0]   brightness;
  logic                  load;
  logic [N_DIGITS-1:0]   anodes;
  logic [7:0]            cathodes;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_start;

  modport master (
    output digits_in, dp_in, blank_in, blink_in, lz_suppress, brightness, load,
    input  anodes, cathodes, digit_idx, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_in, blink_in, lz_suppress, brightness, load,
    output anodes, cathodes, digit_idx, frame_start
  );
endinterface

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan engine: double-buffered frame data, hex glyphs,
// leading-zero suppression, blink and PWM brightness on N_DIGITS digits.
module ssd_digit_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       suppress,
  output logic [7:0] seg
);
  logic [6:0] glyph;

  // active-low {a,b,c,d,e,f,g}
  always_comb begin
    case (nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  end

  assign seg = {suppress ? 7'b1111111 : glyph, ~dp};
endmodule

module ssd_scan_controller #(
  parameter int N_DIGITS      = 8,
  parameter int SCAN_DIV_BITS = 17,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_BITS    = 25
) (
  input logic       board_clk,
  input logic       Reset,
  ssd_scan_if.slave bus
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  typedef struct packed {
    logic [N_DIGITS-1:0][3:0] dig;
    logic [N_DIGITS-1:0]      dp;
    logic [N_DIGITS-1:0]      blank;
    logic [N_DIGITS-1:0]      blink;
    logic                     lz;
  } frame_t;

  // Dark until the first load: every digit blanked.
  localparam frame_t FRAME_RST = frame_t'({{(4*N_DIGITS){1'b0}}, {N_DIGITS{1'b0}},
                                           {N_DIGITS{1'b1}}, {N_DIGITS{1'b0}}, 1'b0});

  logic [SCAN_DIV_BITS-1:0] psc;
  logic [BLINK_BITS-1:0]    blink_cnt;
  logic [IDX_W-1:0]         idx;
  frame_t                   pend, act, in_frame;
  logic                     pend_vld;

  logic [N_DIGITS-1:0]      anodes_q;
  logic [7:0]               cathodes_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     fs_q;

  assign in_frame = {bus.digits_in, bus.dp_in, bus.blank_in, bus.blink_in, bus.lz_suppress};

  // zero_from[i]: active nibbles i..N_DIGITS-1 are all zero
  logic [N_DIGITS:0]          zero_from;
  logic [N_DIGITS-1:0][7:0]   lane_seg;

  assign zero_from[N_DIGITS] = 1'b1;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lane
    logic sup;
    assign zero_from[i] = zero_from[i+1] & (act.dig[i] == 4'h0);
    assign sup = (i != 0) & act.lz & zero_from[i];
    ssd_digit_lane u_lane (
      .nib      (act.dig[i]),
      .dp       (act.dp[i]),
      .suppress (sup),
      .seg      (lane_seg[i])
    );
  end

  logic                wrap, frame_end, pwm_on, lit;
  logic [N_DIGITS-1:0] anode_nxt;
  logic [7:0]          cathode_nxt;

  assign wrap      = &psc;
  assign frame_end = wrap & (idx == LAST_IDX);
  assign pwm_on    = psc[SCAN_DIV_BITS-1 -: PWM_BITS] <= bus.brightness;
  assign lit       = ~act.blank[idx] & ~(act.blink[idx] & blink_cnt[BLINK_BITS-1]) & pwm_on;

  always_comb begin
    anode_nxt   = '1;
    cathode_nxt = 8'hFF;
    if (lit) begin
      anode_nxt   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
      cathode_nxt = lane_seg[idx];
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      psc        <= '0;
      blink_cnt  <= '0;
      idx        <= '0;
      pend       <= FRAME_RST;
      act        <= FRAME_RST;
      pend_vld   <= 1'b0;
      anodes_q   <= '1;
      cathodes_q <= 8'hFF;
      idx_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      psc       <= psc + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (wrap) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      fs_q <= frame_end;

      // Swap only at the frame boundary so a frame never mixes old and new data;
      // a load landing on the boundary itself bypasses the pending copy.
      if (frame_end) begin
        pend_vld <= 1'b0;
        if (bus.load)     act <= in_frame;
        else if (pend_vld) act <= pend;
      end else if (bus.load) begin
        pend     <= in_frame;
        pend_vld <= 1'b1;
      end

      anodes_q   <= anode_nxt;
      cathodes_q <= cathode_nxt;
      idx_q      <= idx;
    end
  end

  assign bus.anodes      = anodes_q;
  assign bus.cathodes    = cathodes_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: cycle model derived from elapsed clock count,
// checked every cycle, plus directed literal checks on glyphs, PWM, blink, buffering.
module tb_ssd_scan_controller;
  localparam int N = 5, SDB = 4, PB = 2, BB = 6;
  localparam int SLOT = 1 << SDB, FRAME = N * SLOT, BHALF = 1 << (BB - 1);

  logic board_clk = 1'b0;
  logic Reset;

  ssd_scan_if #(.N_DIGITS(N), .PWM_BITS(PB)) bus ();

  ssd_scan_controller #(.N_DIGITS(N), .SCAN_DIV_BITS(SDB), .PWM_BITS(PB), .BLINK_BITS(BB)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;

  int nvec = 0, nerr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model: displayed frame, pending frame, and clocks elapsed since reset release.
  logic [19:0] m_dig, p_dig;
  logic [4:0]  m_dp, m_bl, m_bk, p_dp, p_bl, p_bk;
  logic        m_lz, p_lz, m_pv;
  int          k;
  logic [4:0]  e_an;
  logic [7:0]  e_cat;
  logic [2:0]  e_idx;
  logic        e_fs;

  task automatic model_reset();
    k = 0; m_pv = 1'b0;
    m_dig = '0; m_dp = '0; m_bl = '1; m_bk = '0; m_lz = 1'b0;
    p_dig = '0; p_dp = '0; p_bl = '1; p_bk = '0; p_lz = 1'b0;
    e_an = '1; e_cat = 8'hFF; e_idx = '0; e_fs = 1'b0;
  endtask

  task automatic model_step();
    int n, s, psc;
    bit bm, on, sup;
    n   = k;
    s   = (n / SLOT) % N;
    psc = n % SLOT;
    bm  = ((n / BHALF) % 2) == 1;
    on  = !m_bl[s] && !(m_bk[s] && bm) && ((psc >> (SDB - PB)) <= int'(bus.brightness));
    sup = (s >= 1) && m_lz && ((m_dig >> (4 * s)) == 20'h0);
    e_idx = 3'(s);
    e_an  = on ? ~(5'b00001 << s) : 5'b11111;
    e_cat = on ? {sup ? 7'h7F : glyph_tab[m_dig[4*s +: 4]], ~m_dp[s]} : 8'hFF;
    e_fs  = (n % FRAME) == FRAME - 1;
    if ((n % FRAME) == FRAME - 1) begin
      if (bus.load) begin
        m_dig = bus.digits_in; m_dp = bus.dp_in; m_bl = bus.blank_in;
        m_bk = bus.blink_in; m_lz = bus.lz_suppress;
      end else if (m_pv) begin
        m_dig = p_dig; m_dp = p_dp; m_bl = p_bl; m_bk = p_bk; m_lz = p_lz;
      end
      m_pv = 1'b0;
    end else if (bus.load) begin
      p_dig = bus.digits_in; p_dp = bus.dp_in; p_bl = bus.blank_in;
      p_bk = bus.blink_in; p_lz = bus.lz_suppress; m_pv = 1'b1;
    end
    k++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge board_clk or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge board_clk);
      check("anodes", bus.anodes, e_an);
      check("cathodes", bus.cathodes, e_cat);
      check("digit_idx", bus.digit_idx, e_idx);
      check("frame_start", bus.frame_start, e_fs);
    end
  end

  task automatic do_load(input logic [19:0] d, input logic [4:0] dp, input logic [4:0] bl,
                         input logic [4:0] bk, input logic lz);
    bus.digits_in = d; bus.dp_in = dp; bus.blank_in = bl; bus.blink_in = bk;
    bus.lz_suppress = lz; bus.load = 1'b1;
    @(negedge board_clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge board_clk);
      if (bus.frame_start) return;
    end
    check("wait_frame_start_timeout", 0, 1);
  endtask

  task automatic wait_slot(input int s);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (int'(bus.digit_idx) == s && bus.anodes != 5'h1F) return;
      @(negedge board_clk);
    end
    check("wait_slot_timeout", s, 99);
  endtask

  initial begin
    int lit, cyc, fs_last, fs_gap, prev, cnt, dark1, lit1, other_dark;
    int bvals[2] = '{1, 0};
    int bexp[2]  = '{8, 4};
    Reset = 1'b1;
    bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.blink_in = '0;
    bus.lz_suppress = 1'b0; bus.brightness = 2'd3; bus.load = 1'b0;
    repeat (3) @(negedge board_clk);
    check("rst_anodes", bus.anodes, 5'h1F);
    check("rst_cathodes", bus.cathodes, 8'hFF);
    check("rst_digit_idx", bus.digit_idx, 0);
    check("rst_frame_start", bus.frame_start, 0);
    Reset = 1'b0;

    // no load yet: dark display, frame_start every FRAME clocks
    lit = 0; cyc = 0; fs_last = -1; fs_gap = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge board_clk);
      cyc++;
      if (bus.anodes != 5'h1F || bus.cathodes != 8'hFF) lit++;
      if (bus.frame_start) begin
        if (fs_last >= 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
    end
    check("dark_before_load", lit, 0);
    check("frame_period", fs_gap, 80);

    do_load(20'h0A3F1, 5'b0, 5'b0, 5'b0, 1'b0);
    wait_fs();
    wait_slot(0); check("glyph_1", bus.cathodes, 8'b10011111);
    wait_slot(1); check("glyph_F", bus.cathodes, 8'b01110001);
    wait_slot(4); check("glyph_0", bus.cathodes, 8'b00000011);

    do_load(20'h0A3F1, 5'b0, 5'b0, 5'b0, 1'b1);
    wait_fs();
    wait_slot(3); check("lz_digit3_A", bus.cathodes, 8'b00010001);
    wait_slot(4); check("lz_digit4_anode", bus.anodes, 5'b01111);
    check("lz_digit4_dark", bus.cathodes, 8'hFF);

    do_load(20'h00000, 5'b0, 5'b0, 5'b0, 1'b1);
    wait_fs();
    wait_slot(0); check("lz_zero_digit0", bus.cathodes, 8'b00000011);
    wait_slot(1); check("lz_zero_digit1", bus.cathodes, 8'hFF);

    // PWM duty measured over one whole slot
    for (int b = 0; b < 2; b++) begin
      bus.brightness = 2'(bvals[b]);
      prev = int'(bus.digit_idx);
      for (int i = 0; i < 40 && int'(bus.digit_idx) == prev; i++) @(negedge board_clk);
      cnt = 0;
      for (int j = 0; j < SLOT; j++) begin
        if (bus.anodes != 5'h1F) cnt++;
        @(negedge board_clk);
      end
      check("pwm_on_cycles", cnt, bexp[b]);
    end
    bus.brightness = 2'd3;

    // four frames put digit1's slot once in each quarter of the blink period
    do_load(20'h0A3F1, 5'b0, 5'b0, 5'b00010, 1'b0);
    wait_fs();
    dark1 = 0; lit1 = 0; other_dark = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (bus.digit_idx == 3'd1) begin
        if (bus.anodes == 5'b11101) lit1++;
        else if (bus.anodes == 5'b11111) dark1++;
      end else if (bus.anodes == 5'b11111) other_dark++;
      @(negedge board_clk);
    end
    check("blink_dark_cycles", dark1, 32);
    check("blink_lit_cycles", lit1, 32);
    check("blink_others_dark", other_dark, 0);

    // mid-frame load waits for the boundary
    do_load(20'h0A3F1, 5'b0, 5'b0, 5'b0, 1'b0);
    wait_fs();
    wait_slot(2);
    do_load(20'h12345, 5'b00001, 5'b0, 5'b0, 1'b0);
    wait_slot(4); check("midload_old_digit4", bus.cathodes, 8'b00000011);
    wait_fs();
    wait_slot(0); check("midload_new_digit0_dp", bus.cathodes, 8'b01001000);
    wait_slot(4); check("midload_new_digit4", bus.cathodes, 8'b10011111);

    // load landing exactly on the wrap cycle
    wait_fs();
    repeat (FRAME - 1) @(negedge board_clk);
    do_load(20'h6789B, 5'b0, 5'b0, 5'b0, 1'b0);
    check("wrap_frame_start", bus.frame_start, 1);
    wait_slot(0); check("wrap_new_digit0_b", bus.cathodes, 8'b11000001);
    wait_slot(4); check("wrap_new_digit4_6", bus.cathodes, 8'b01000001);

    // reset mid-frame with a pending load
    wait_slot(3);
    do_load(20'hFFFFF, 5'b0, 5'b0, 5'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("midrst_anodes", bus.anodes, 5'h1F);
    check("midrst_cathodes", bus.cathodes, 8'hFF);
    check("midrst_digit_idx", bus.digit_idx, 0);
    @(negedge board_clk);
    Reset = 1'b0;
    lit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge board_clk);
      if (bus.anodes != 5'h1F) lit++;
    end
    check("pending_discarded", lit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    nvec++; nerr++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
